// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e     : operation codes carried on mdu_op (unlisted codes mean "none")
//   - MDU_OP_W     : width of the mdu_op field
//   - CNT_W        : width of the busy-cycle counter
//   - MULT_CYCLES  : default busy length of mult/multu
//   - DIV_CYCLES   : default busy length of div/divu
package mdu_pkg;

  localparam int MDU_OP_W = 4;
  localparam int CNT_W    = 16;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage request/response bundle of the multiply/divide unit.
//   req     : exception taken at M, the EX instruction is being flushed
//   mdu_op  : operation code (see mdu_pkg::mdu_op_e)
//   rs, rt  : forwarded operands
//   start   : a mult/div is accepted this cycle
//   busy    : a mult/div is in progress
//   mdu_out : HI/LO read data for mfhi/mflo, zero otherwise
// master = pipeline side (drives the request), slave = the mdu.
interface mdu_if;
  import mdu_pkg::*;

  logic                req;
  logic [MDU_OP_W-1:0] mdu_op;
  logic [31:0]         rs;
  logic [31:0]         rt;
  logic                start;
  logic                busy;
  logic [31:0]         mdu_out;

  modport master (
    output req, mdu_op, rs, rt,
    input  start, busy, mdu_out
  );

  modport slave (
    input  req, mdu_op, rs, rt,
    output start, busy, mdu_out
  );
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (aborts any operation, clears HI/LO)
//   bus   : mdu_if slave port (req, mdu_op, rs, rt in; start, busy, mdu_out out)
// The result is computed in the start cycle and parked in ph/pl; busy then
// holds for MULT_CYCLES or DIV_CYCLES and HI/LO are updated on the last busy
// edge so the visible latency matches a real iterative unit.
// Stall contract for the hazard unit: stall D whenever the D instruction is
// any MDU op and (start | busy).
import mdu_pkg::*;

module mdu #(
  parameter int unsigned MULT_CYCLES = mdu_pkg::MULT_CYCLES,  // >= 1
  parameter int unsigned DIV_CYCLES  = mdu_pkg::DIV_CYCLES    // >= 1
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      ph_q, ph_d;
  logic [31:0]      pl_q, pl_d;
  logic             dz_q, dz_d;     // pending op was a divide by zero
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operation decode
  logic is_mul, is_div, is_signed;

  always_comb begin
    is_mul    = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_MULTU);
    is_div    = (bus.mdu_op == MDU_DIV)  || (bus.mdu_op == MDU_DIVU);
    is_signed = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_DIV);
  end

  assign bus.start = (is_mul || is_div) && !busy_q && !bus.req;
  assign bus.busy  = busy_q;

  always_comb begin
    bus.mdu_out = 32'd0;
    if (bus.mdu_op == MDU_MFHI) bus.mdu_out = hi_q;
    if (bus.mdu_op == MDU_MFLO) bus.mdu_out = lo_q;
  end

  // Arithmetic. The signed multiply uses sign-extended operands: the low 64
  // bits of that unsigned product equal the two's-complement product.
  // Division works on magnitudes and fixes signs afterwards, which gives
  // truncation toward zero, a remainder signed like the dividend, and
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  logic [63:0] rs_ext, rt_ext, prod;
  logic        rs_neg, rt_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  always_comb begin
    rs_ext = is_signed ? {{32{bus.rs[31]}}, bus.rs} : {32'd0, bus.rs};
    rt_ext = is_signed ? {{32{bus.rt[31]}}, bus.rt} : {32'd0, bus.rt};
    prod   = rs_ext * rt_ext;

    rs_neg = is_signed && bus.rs[31];
    rt_neg = is_signed && bus.rt[31];
    a_mag  = rs_neg ? (~bus.rs + 32'd1) : bus.rs;
    b_mag  = rt_neg ? (~bus.rt + 32'd1) : bus.rt;
    // Divide by zero never commits; a dummy divisor keeps the datapath defined.
    b_div  = (bus.rt == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quot   = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = rs_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Next-state logic
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    ph_d   = ph_q;
    pl_d   = pl_q;
    dz_d   = dz_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;

    if (busy_q) begin
      // req is deliberately ignored here: the running op is already committed.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (!dz_q) begin
          hi_d = ph_q;
          lo_d = pl_q;
        end
      end
    end else if (bus.start) begin
      busy_d = 1'b1;
      if (is_mul) begin
        ph_d  = prod[63:32];
        pl_d  = prod[31:0];
        dz_d  = 1'b0;
        cnt_d = CNT_W'(MULT_CYCLES);
      end else begin
        ph_d  = rem;
        pl_d  = quot;
        dz_d  = (bus.rt == 32'd0);
        cnt_d = CNT_W'(DIV_CYCLES);
      end
    end else if (!bus.req) begin
      if (bus.mdu_op == MDU_MTHI) hi_d = bus.rs;
      if (bus.mdu_op == MDU_MTLO) lo_d = bus.rs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      ph_q   <= 32'd0;
      pl_q   <= 32'd0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      ph_q   <= ph_d;
      pl_q   <= pl_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed test of the mdu with hand-computed expected values.
import mdu_pkg::*;

module tb_mdu;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mdu_if bus ();

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; reads HI then LO combinationally.
  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.mdu_op = MDU_MFHI;
    #1;
    check({tag, " hi"}, bus.mdu_out, exp_hi);
    bus.mdu_op = MDU_MFLO;
    #1;
    check({tag, " lo"}, bus.mdu_out, exp_lo);
    bus.mdu_op = MDU_NONE;
  endtask

  task automatic write_hilo(input mdu_op_e op, input logic [31:0] val);
    bus.mdu_op = op;
    bus.rs     = val;
    @(posedge clk); #1;
    bus.mdu_op = MDU_NONE;
    $display("write op=%0d val=0x%08h", op, val);
  endtask

  // Counts busy cycles with a bounded wait and returns the count.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    bus.mdu_op = op;
    bus.rs     = a;
    bus.rt     = b;
    #1;
    check({tag, " start"}, 32'(bus.start), 32'd1);
    @(posedge clk); #1;
    bus.mdu_op = MDU_NONE;
    count_busy(n);
    check({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
    read_hilo(tag, exp_hi, exp_lo);
    $display("op %s rs=0x%08h rt=0x%08h busy=%0d", tag, a, b, n);
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.req    = 1'b0;
    bus.mdu_op = MDU_NONE;
    bus.rs     = 32'd0;
    bus.rt     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset start", 32'(bus.start), 32'd0);
    check("none out", bus.mdu_out, 32'd0);
    read_hilo("reset", 32'd0, 32'd0);

    // Main arithmetic
    run_op("mult",  MDU_MULT,  32'hFFFF_FFFD, 32'd5, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFD, 32'd5, 5,  32'h0000_0004, 32'hFFFF_FFF1);
    run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  MDU_DIVU,  32'd100,       32'd7, 10, 32'd2,         32'd14);
    run_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // Divide by zero leaves HI/LO untouched
    write_hilo(MDU_MTHI, 32'h0000_1234);
    write_hilo(MDU_MTLO, 32'h0000_5678);
    read_hilo("mthi/mtlo", 32'h0000_1234, 32'h0000_5678);
    run_op("divu by 0", MDU_DIVU, 32'd7, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);

    // req blocks start and mthi
    bus.req    = 1'b1;
    bus.mdu_op = MDU_MULT;
    bus.rs     = 32'd3;
    bus.rt     = 32'd4;
    #1;
    check("req start", 32'(bus.start), 32'd0);
    @(posedge clk); #1;
    check("req busy", 32'(bus.busy), 32'd0);
    bus.mdu_op = MDU_MTHI;
    bus.rs     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    read_hilo("req blocked", 32'h0000_1234, 32'h0000_5678);
    $display("op req-blocked mult/mthi");

    // req during an active div does not abort it; old HI visible while busy
    bus.mdu_op = MDU_DIV;
    bus.rs     = 32'hFFFF_FF9C;  // -100
    bus.rt     = 32'd7;
    @(posedge clk); #1;
    bus.mdu_op = MDU_MFHI;
    bus.req    = 1'b1;
    #1;
    check("busy old hi", bus.mdu_out, 32'h0000_1234);
    bus.mdu_op = MDU_NONE;
    count_busy(n);
    bus.req = 1'b0;
    check("req div cycles", 32'(n), 32'd10);
    read_hilo("req div", 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    $display("op div under req busy=%0d", n);

    // Reset on the 3rd busy cycle of a mult
    bus.mdu_op = MDU_MULT;
    bus.rs     = 32'd3;
    bus.rt     = 32'd7;
    @(posedge clk); #1;       // busy cycle 1
    bus.mdu_op = MDU_NONE;
    @(posedge clk); #1;       // busy cycle 2
    @(posedge clk); #1;       // busy cycle 3
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("no late busy", 32'(bus.busy), 32'd0);
    read_hilo("no late commit", 32'd0, 32'd0);
    $display("op mult aborted by reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
